// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared defaults, state encoding and sample type for the block floating-point shift controller
package bfp_pkg;

    localparam int DEF_INPUT_WIDTH  = 23;
    localparam int DEF_OUTPUT_WIDTH = 11;
    localparam int DEF_BLOCK_SIZE   = 16;
    localparam int DEF_SHIFT_WIDTH  = 5;
    localparam int CNT_WIDTH        = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC,
        HOLD
    } state_t;

    typedef logic signed [DEF_INPUT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/bfp_shift_ctrl_if.sv
// rtl/bfp_shift_ctrl_if.sv - sample input and block output bundle of the shift controller
interface bfp_shift_ctrl_if
    import bfp_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
);

    logic                                   in_valid;
    logic                                   in_ready;
    logic signed [INPUT_WIDTH-1:0]          in_re;
    logic signed [INPUT_WIDTH-1:0]          in_im;
    logic                                   out_valid;
    logic                                   out_ready;
    logic                                   shift_en;
    logic [SHIFT_WIDTH-1:0]                 shift_value;
    logic [BLOCK_SIZE-1:0][INPUT_WIDTH-1:0] blk_re;
    logic [BLOCK_SIZE-1:0][INPUT_WIDTH-1:0] blk_im;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, shift_en, shift_value, blk_re, blk_im
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, shift_en, shift_value, blk_re, blk_im
    );

endinterface

// File: rtl/signed_width_calc.sv
// rtl/signed_width_calc.sv - minimal two's-complement width of a signed sample (1..INPUT_WIDTH)
module signed_width_calc #(
    parameter int INPUT_WIDTH = 23,
    parameter int WIDTH_BITS  = 5
) (
    input  logic signed [INPUT_WIDTH-1:0] x_i,
    output logic [WIDTH_BITS-1:0]         width_o
);

    // The highest bit that differs from the sign bit sets the width; later iterations win.
    always_comb begin
        width_o = WIDTH_BITS'(1);
        for (int i = 0; i < INPUT_WIDTH - 1; i++) begin
            if (x_i[i] != x_i[INPUT_WIDTH-1]) begin
                width_o = WIDTH_BITS'(i + 2);
            end
        end
    end

endmodule

// File: rtl/bfp_shift_ctrl.sv
// rtl/bfp_shift_ctrl.sv - buffers a block of complex samples and derives one right-shift for the whole block
module bfp_shift_ctrl
    import bfp_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
    parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    bfp_shift_ctrl_if.slave bus
);

    localparam int WB = $clog2(INPUT_WIDTH + 1);

    state_t                                 state_q, state_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
    logic [WB-1:0]                          w_q, w_d;
    logic [SHIFT_WIDTH-1:0]                 shift_q, shift_d;
    logic [BLOCK_SIZE-1:0][INPUT_WIDTH-1:0] buf_re_q, buf_im_q;
    logic [WB-1:0]                          w_re, w_im, w_pair;
    logic                                   in_ready, accept, last;

    signed_width_calc #(.INPUT_WIDTH(INPUT_WIDTH), .WIDTH_BITS(WB)) u_width_re (
        .x_i     (bus.in_re),
        .width_o (w_re)
    );

    signed_width_calc #(.INPUT_WIDTH(INPUT_WIDTH), .WIDTH_BITS(WB)) u_width_im (
        .x_i     (bus.in_im),
        .width_o (w_im)
    );

    assign in_ready = (state_q == IDLE) || (state_q == FILL);
    assign accept   = bus.in_valid && in_ready;
    assign last     = (cnt_q == CNT_WIDTH'(BLOCK_SIZE - 1));
    assign w_pair   = (w_re > w_im) ? w_re : w_im;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        shift_d = shift_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    // The first sample of a block reloads W so the previous block cannot leak in.
                    w_d = (state_q == IDLE || w_pair > w_q) ? w_pair : w_q;
                    if (last) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = FILL;
                    end
                end
            end
            CALC: begin
                shift_d = (w_q > WB'(OUTPUT_WIDTH)) ? SHIFT_WIDTH'(w_q - WB'(OUTPUT_WIDTH)) : '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= WB'(1);
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_re_q <= '0;
            buf_im_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                if (cnt_q == CNT_WIDTH'(k)) begin
                    buf_re_q[k] <= bus.in_re;
                    buf_im_q[k] <= bus.in_im;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.shift_en    = (state_q == HOLD);
    assign bus.shift_value = shift_q;
    assign bus.blk_re      = buf_re_q;
    assign bus.blk_im      = buf_im_q;

endmodule

// File: tb/tb_bfp_shift_ctrl.sv
// tb/tb_bfp_shift_ctrl.sv - scoreboard bench for bfp_shift_ctrl with directed and random blocks
module tb_bfp_shift_ctrl;
    import bfp_pkg::*;

    localparam int IW = DEF_INPUT_WIDTH;
    localparam int OW = DEF_OUTPUT_WIDTH;
    localparam int BS = DEF_BLOCK_SIZE;
    localparam int SW = DEF_SHIFT_WIDTH;

    typedef struct {
        int shift;
        int re[BS];
        int im[BS];
        int valid_cyc;
    } exp_t;

    exp_t sb[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cur_re[BS];
    int   cur_im[BS];
    bit   rand_ready = 1'b0;

    bfp_shift_ctrl_if #(.INPUT_WIDTH(IW), .BLOCK_SIZE(BS), .SHIFT_WIDTH(SW)) bus ();

    bfp_shift_ctrl #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .BLOCK_SIZE  (BS),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Smallest w such that -2^(w-1) <= x <= 2^(w-1)-1.
    function automatic int ref_width(input int x);
        for (int w = 1; w <= IW; w++) begin
            if (x >= -(1 <<< (w - 1)) && x <= (1 <<< (w - 1)) - 1) return w;
        end
        return IW;
    endfunction

    function automatic exp_t make_exp(input int vcyc);
        exp_t e;
        int   wmax;
        wmax = 1;
        for (int k = 0; k < BS; k++) begin
            e.re[k] = cur_re[k];
            e.im[k] = cur_im[k];
            if (ref_width(cur_re[k]) > wmax) wmax = ref_width(cur_re[k]);
            if (ref_width(cur_im[k]) > wmax) wmax = ref_width(cur_im[k]);
        end
        e.shift     = (wmax > OW) ? wmax - OW : 0;
        e.valid_cyc = vcyc;
        return e;
    endfunction

    function automatic int rand_sample();
        int b;
        int v;
        if ($urandom_range(3) == 0) return 0;
        b = $urandom_range(1, IW);
        v = int'($urandom);
        v = (v <<< (32 - b)) >>> (32 - b);
        return v;
    endfunction

    task automatic clear_cur();
        for (int k = 0; k < BS; k++) begin
            cur_re[k] = 0;
            cur_im[k] = 0;
        end
    endtask

    task automatic wait_accept(input bit is_last);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(bus.in_ready == 1'b1, "accept_wait", int'(bus.in_ready), 1);
        if (is_last) begin
            e = make_exp(cyc + 2);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // gap: 0 back-to-back, 1 in_valid toggling every cycle, 2 random idle gaps
    task automatic send_block(input int count, input int gap);
        for (int k = 0; k < count; k++) begin
            if (gap == 1 && k > 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end else if (gap == 2 && $urandom_range(3) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_re    = IW'(cur_re[k]);
            bus.in_im    = IW'(cur_im[k]);
            wait_accept(k == BS - 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check(sb.size() == 0, "drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        int bad;
        bad = 0;
        check(bus.out_valid == 1'b0, {tag, "_out_valid"}, int'(bus.out_valid), 0);
        check(bus.shift_en == 1'b0, {tag, "_shift_en"}, int'(bus.shift_en), 0);
        check(bus.shift_value == '0, {tag, "_shift_value"}, int'(bus.shift_value), 0);
        check(bus.in_ready == 1'b1, {tag, "_in_ready"}, int'(bus.in_ready), 1);
        for (int k = 0; k < BS; k++) begin
            if (bus.blk_re[k] != '0 || bus.blk_im[k] != '0) bad++;
        end
        check(bad == 0, {tag, "_buffer_nonzero_entries"}, bad, 0);
    endtask

    initial begin
        bit   first;
        bit   post;
        int   bad;
        int   got_v;
        int   exp_v;
        exp_t e;
        first = 1'b1;
        post  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                first = 1'b1;
                post  = 1'b0;
            end else begin
                if (post) begin
                    check(bus.in_ready == 1'b1 && bus.out_valid == 1'b0, "post_handshake_ready",
                          int'({bus.in_ready, bus.out_valid}), 2);
                    post = 1'b0;
                end
                check(bus.shift_en == bus.out_valid, "shift_en_eq_out_valid",
                      int'(bus.shift_en), int'(bus.out_valid));
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_out_valid", 1, 0);
                    end else begin
                        e = sb[0];
                        if (first) begin
                            check(cyc == e.valid_cyc, "out_valid_latency", cyc, e.valid_cyc);
                            first = 1'b0;
                        end
                        check(int'(bus.shift_value) == e.shift, "shift_value", int'(bus.shift_value), e.shift);
                        check(bus.in_ready == 1'b0, "in_ready_in_hold", int'(bus.in_ready), 0);
                        bad   = -1;
                        got_v = 0;
                        exp_v = 0;
                        for (int k = 0; k < BS; k++) begin
                            if (bad < 0 && int'($signed(bus.blk_re[k])) != e.re[k]) begin
                                bad = k; got_v = int'($signed(bus.blk_re[k])); exp_v = e.re[k];
                            end
                            if (bad < 0 && int'($signed(bus.blk_im[k])) != e.im[k]) begin
                                bad = k; got_v = int'($signed(bus.blk_im[k])); exp_v = e.im[k];
                            end
                        end
                        check(bad < 0, "block_data", got_v, exp_v);
                        if (bus.out_ready) begin
                            void'(sb.pop_front());
                            first = 1'b1;
                            post  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(1));
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("after_reset");
        @(posedge clk);
        #1;

        clear_cur();
        send_block(BS, 0);
        drain();

        clear_cur();
        cur_re[5] = 1024;
        send_block(BS, 0);
        drain();

        clear_cur();
        cur_im[9] = -4194304;
        send_block(BS, 0);
        drain();

        clear_cur();
        cur_im[3] = -1024;
        send_block(BS, 0);
        drain();

        clear_cur();
        for (int k = 0; k < BS; k++) begin
            cur_re[k] = k;
            cur_im[k] = -k;
        end
        send_block(BS, 1);
        drain();

        // Stall HOLD for ~10 cycles while the next block is already waiting.
        bus.out_ready = 1'b0;
        for (int k = 0; k < BS; k++) begin
            cur_re[k] = rand_sample();
            cur_im[k] = rand_sample();
        end
        send_block(BS, 0);
        fork
            begin
                repeat (12) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < BS; k++) begin
            cur_re[k] = rand_sample();
            cur_im[k] = rand_sample();
        end
        send_block(BS, 0);
        drain();

        clear_cur();
        cur_re[2] = -4194304;
        send_block(7, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_fill_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clear_cur();
        cur_re[10] = 2000;
        send_block(BS, 0);
        drain();

        rand_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < BS; k++) begin
                cur_re[k] = rand_sample();
                cur_im[k] = rand_sample();
            end
            send_block(BS, 2);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfp_shift_ctrl.md
BFP_SHIFT_CTRL -- requirements
Module: bfp_shift_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- INPUT_WIDTH, default 23, sample width in bits.
- OUTPUT_WIDTH, default 11, post-shift width in bits.
- BLOCK_SIZE, default 16, samples per block.
- SHIFT_WIDTH, default 5, width of shift_value.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assertion, active-high.
REQ-004 in_valid  input  1  sample offered.
REQ-005 in_ready  output  1  controller accepts a sample this cycle.
REQ-006 in_re / in_im  input  INPUT_WIDTH signed each  complex sample.
REQ-007 out_valid  output  1  buffered block and shift_value valid.
REQ-008 out_ready  input  1  downstream consumes the block.
REQ-009 shift_en  output  1  enable to the downstream 16-lane bit-shift array; equals out_valid.
REQ-010 shift_value  output  SHIFT_WIDTH  right-shift amount for the whole block.
REQ-011 blk_re / blk_im  output  INPUT_WIDTH signed x BLOCK_SIZE each  buffered block; index 0 is the first accepted sample.

Function
REQ-012 The state machine SHALL have four states:
- IDLE -> FILL on the first accepted sample.
- FILL -> CALC on acceptance of sample BLOCK_SIZE-1.
- CALC -> HOLD unconditionally after 1 cycle.
- HOLD -> IDLE when out_valid && out_ready.
REQ-013 A sample SHALL be accepted only when in_valid && in_ready.
REQ-014 in_ready SHALL be 1 in IDLE and FILL and 0 in CALC and HOLD.
REQ-015 A 5-bit write counter SHALL index the buffer, increment per accepted sample, and clear to 0 on entering CALC.
REQ-016 in_valid deasserted mid-FILL SHALL stall the counter with buffer contents preserved; there is no timeout.
REQ-017 Minimal signed width w(x), range 1..INPUT_WIDTH, SHALL be computed for re and im of every accepted sample:
- w(0) = w(-1) = 1.
- w(1023) = w(-1024) = 11.
- w(1024) = 12.
- w(-2^22) = 23.
REQ-018 Running block width W SHALL update as W <= max(W, w(re), w(im)) per accepted sample.
REQ-019 W SHALL load max(w(re), w(im)) on the first sample of a block, not max with the stale value.
REQ-020 In CALC, shift_value SHALL be registered as W - OUTPUT_WIDTH when W > OUTPUT_WIDTH, else 0; range 0..12.
REQ-021 out_valid SHALL assert in HOLD only, first asserting 2 cycles after the cycle accepting the last sample.
REQ-022 blk_re, blk_im and shift_value SHALL remain stable while out_valid=1.
REQ-023 A handshake on the first HOLD cycle SHALL be legal, giving 1-cycle HOLD.
REQ-024 The next block's first sample SHALL not be accepted before the cycle after the handshake; throughput is at most one block per BLOCK_SIZE+2 cycles.
REQ-025 out_ready=0 SHALL hold HOLD indefinitely with no sample loss and in_ready=0.

Reset
REQ-026 rst=1 SHALL asynchronously force:
- state IDLE, counter 0, W 1;
- shift_value 0, out_valid 0, shift_en 0;
- in_ready 1 after release;
- all buffer entries 0.
REQ-027 Reset mid-FILL or mid-HOLD SHALL discard the partial or pending block; no output SHALL be produced for it.

Structure
REQ-028 Package bfp_pkg SHALL hold:
- the INPUT_WIDTH, OUTPUT_WIDTH, BLOCK_SIZE and SHIFT_WIDTH defaults;
- the state enum (IDLE, FILL, CALC, HOLD);
- the sample typedef.
REQ-029 One combinational sub-module, signed_width_calc, SHALL compute w(x); it SHALL be instantiated twice, once for re and once for im.
REQ-030 The buffer SHALL be a flop array, and shift_value SHALL be registered with no combinational path from in_* to out_*.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- 16 samples re=im=0, back-to-back, out_ready=1 -> out_valid 2 cycles after the last sample, shift_value=0, 1-cycle HOLD.
- One sample re=1024, others 0 -> shift_value=1.
- One sample im=-4194304 -> shift_value=12; sample im=-1024 alone -> shift_value=0.
- in_valid toggling 1/0 every cycle -> block completes after 32 cycles, buffer order intact, blk_re[k]=k.
- out_ready=0 for 10 HOLD cycles -> outputs stable, in_ready=0, then the next block accepted from the cycle after the handshake.
- rst pulse after 7 samples -> no out_valid; the next 16 samples form a clean block whose shift_value reflects only those 16.
